// File: rtl/melody_pkg.sv
// melody_pkg: FSM state type, note-entry field widths and the constant note table.
package melody_pkg;
    localparam int DIV_W  = 16;
    localparam int DUR_W  = 10;
    localparam int NOTE_W = DIV_W + DUR_W;
    localparam int IDX_W  = 3;

    typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_GAP} state_t;
    typedef logic [NOTE_W-1:0] note_t;
    typedef logic [DIV_W-1:0]  div_t;
    typedef logic [DUR_W-1:0]  dur_t;

    // {div, dur_ms}; div == 0 is a rest
    function automatic note_t note_at(input logic [IDX_W-1:0] i);
        case (i)
            3'd0:    return {16'd56817, 10'd3};
            3'd1:    return {16'd0,     10'd2};
            3'd2:    return {16'd28408, 10'd0};
            default: return {16'd37936, 10'd1};
        endcase
    endfunction

    function automatic div_t note_div(input logic [IDX_W-1:0] i);
        note_t n;
        n = note_at(i);
        return n[NOTE_W-1:DUR_W];
    endfunction

    function automatic dur_t note_dur(input logic [IDX_W-1:0] i);
        note_t n;
        n = note_at(i);
        return n[DUR_W-1:0];
    endfunction
endpackage

// File: rtl/ms_tick_gen.sv
// ms_tick_gen: 1 ms prescaler with synchronous clear; o_tick_nx is the tick as it
// will appear next cycle, so the parent can register outputs one cycle ahead.
module ms_tick_gen #(
    parameter int TICKS = 50000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_tick,
    output logic o_tick_nx
);
    localparam int PW = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICKS - 1);

    logic [PW-1:0] r_cnt;
    logic [PW-1:0] w_cnt_nx;

    assign w_cnt_nx  = (i_clr || r_cnt == LAST) ? '0 : r_cnt + PW'(1);
    assign o_tick    = (r_cnt == LAST);
    assign o_tick_nx = (w_cnt_nx == LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_cnt <= '0;
        else          r_cnt <= w_cnt_nx;
    end
endmodule

// File: rtl/alarm_melody_seq.sv
// alarm_melody_seq: plays the note table REPEAT times, each note followed by a silent gap.
// Every output is registered from next-state values, so Done is predicted one cycle early.
module alarm_melody_seq
    import melody_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int GAP_MS = 20,
    parameter int REPEAT = 3
) (
    input  logic             i_clk_50mhz,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    output logic [DIV_W-1:0] o_tone_div,
    output logic             o_tone_on,
    output logic             o_busy,
    output logic [IDX_W-1:0] o_note_idx,
    output logic             o_done
);
    localparam int               TICKS_PER_MS = CLK_HZ / 1000;
    localparam dur_t             GAP_LIM      = dur_t'(GAP_MS);
    localparam logic [3:0]       PASSES       = 4'(REPEAT);
    localparam logic [IDX_W-1:0] LAST_IDX     = '1;

    logic [1:0]       r_rst_sync;
    logic             w_rst_n;
    state_t           r_state, w_state_nx;
    logic [IDX_W-1:0] r_idx, w_idx_nx;
    logic [3:0]       r_pass, w_pass_nx;
    dur_t             r_ms, w_ms_nx, w_lim;
    logic             w_clr, w_hold, w_tick, w_tick_nx, w_end, w_done_nx;
    div_t             r_tone_div;
    logic             r_tone_on, r_busy, r_done;

    always_ff @(posedge i_clk_50mhz or negedge i_rst_n) begin
        if (!i_rst_n) r_rst_sync <= '0;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // Counters sit at zero in IDLE and restart on every state entry
    assign w_hold = w_clr || (r_state == ST_IDLE);

    ms_tick_gen #(.TICKS(TICKS_PER_MS)) u_tick (
        .i_clk     (i_clk_50mhz),
        .i_rst_n   (w_rst_n),
        .i_clr     (w_hold),
        .o_tick    (w_tick),
        .o_tick_nx (w_tick_nx)
    );

    assign w_lim   = (r_state == ST_PLAY) ? note_dur(r_idx) : GAP_LIM;
    assign w_end   = w_tick && (r_ms == w_lim - dur_t'(1));
    assign w_ms_nx = w_hold ? '0 : r_ms + dur_t'(w_tick);

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_pass_nx  = r_pass;
        w_clr      = 1'b0;
        if (i_stop) begin
            w_state_nx = ST_IDLE;
            w_clr      = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: if (i_start) begin
                    w_clr      = 1'b1;
                    w_idx_nx   = '0;
                    w_pass_nx  = PASSES;
                    w_state_nx = (note_dur('0) == '0) ? ST_GAP : ST_PLAY;
                end
                ST_PLAY: if (w_end) begin
                    w_clr      = 1'b1;
                    w_state_nx = ST_GAP;
                end
                default: if (w_end) begin
                    w_clr = 1'b1;
                    if (r_idx == LAST_IDX && r_pass == 4'd1) begin
                        w_state_nx = ST_IDLE;
                        w_pass_nx  = '0;
                    end else begin
                        w_idx_nx   = r_idx + IDX_W'(1);
                        w_pass_nx  = (r_idx == LAST_IDX) ? r_pass - 4'd1 : r_pass;
                        w_state_nx = (note_dur(w_idx_nx) == '0) ? ST_GAP : ST_PLAY;
                    end
                end
            endcase
        end
    end

    // High when the coming cycle is the last one of the final gap
    assign w_done_nx = (w_state_nx == ST_GAP) && (w_idx_nx == LAST_IDX) && (w_pass_nx == 4'd1)
                       && w_tick_nx && (w_ms_nx == GAP_LIM - dur_t'(1));

    always_ff @(posedge i_clk_50mhz or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_pass     <= '0;
            r_ms       <= '0;
            r_tone_div <= '0;
            r_tone_on  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_idx      <= w_idx_nx;
            r_pass     <= w_pass_nx;
            r_ms       <= w_ms_nx;
            r_tone_div <= (w_clr && w_state_nx == ST_PLAY) ? note_div(w_idx_nx) : r_tone_div;
            r_tone_on  <= (w_state_nx == ST_PLAY) && (note_div(w_idx_nx) != '0);
            r_busy     <= (w_state_nx != ST_IDLE);
            r_done     <= w_done_nx;
        end
    end

    assign o_tone_div = r_tone_div;
    assign o_tone_on  = r_tone_on;
    assign o_busy     = r_busy;
    assign o_note_idx = r_idx;
    assign o_done     = r_done;
endmodule

// File: tb/tb_alarm_melody_seq.sv
// tb_alarm_melody_seq: expected output-change events (cycle stamp + value) are queued by
// the stimulus; a monitor compares every observed change and flags missed events.
module tb_alarm_melody_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] tone_div;
    logic        tone_on, busy, done;
    logic [2:0]  note_idx;

    typedef struct {
        int          cyc;
        logic [21:0] val;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   base = 0;
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;

    alarm_melody_seq #(.CLK_HZ(4000), .GAP_MS(2), .REPEAT(2)) dut (
        .i_clk_50mhz (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_stop      (stop),
        .o_tone_div  (tone_div),
        .o_tone_on   (tone_on),
        .o_busy      (busy),
        .o_note_idx  (note_idx),
        .o_done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic exp_ev(input int k, input logic [15:0] d, input logic on, input logic bz,
                          input logic [2:0] idx, input logic dn, input string tag);
        exp_t e;
        e.cyc  = base + k;
        e.val  = {d, on, bz, idx, dn};
        e.name = $sformatf("%s_k%0d", tag, k);
        q.push_back(e);
    endtask

    task automatic wait_k(input int k);
        while (cyc < base + k) @(negedge clk);
    endtask

    task automatic pulse_start();
        base  = cyc + 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    // Monitor
    initial begin
        logic [21:0] cur, prev;
        logic        rst_prev;
        bit          first;
        exp_t        e;
        prev     = '0;
        rst_prev = 1'b0;
        first    = 1'b1;
        forever begin
            @(negedge clk or negedge rst_n);
            if (rst_prev && !rst_n) begin
                #1;
                checks++;
                if (tone_on !== 1'b0) begin
                    failures++;
                    $display("FAIL async_reset_tone_on got=%b want=0", tone_on);
                end
            end else if (mon_en) begin
                cur = {tone_div, tone_on, busy, note_idx, done};
                if (first) begin
                    first = 1'b0;
                    checks++;
                    if (cur !== 22'd0) begin
                        failures++;
                        $display("FAIL reset_state got=%h want=0", cur);
                    end
                end else begin
                    while (q.size() > 0 && q[0].cyc < cyc) begin
                        e = q.pop_front();
                        checks++;
                        failures++;
                        $display("FAIL %s missed got=%h want=%h at cyc %0d", e.name, cur, e.val, e.cyc);
                    end
                    if (cur !== prev) begin
                        checks++;
                        if (q.size() == 0 || q[0].cyc != cyc) begin
                            failures++;
                            $display("FAIL unexpected_change got=%h was=%h cyc=%0d", cur, prev, cyc);
                        end else begin
                            e = q.pop_front();
                            if (cur !== e.val) begin
                                failures++;
                                $display("FAIL %s got=%h want=%h", e.name, cur, e.val);
                            end
                        end
                    end
                end
                prev = cur;
            end
            rst_prev = rst_n;
        end
    end

    // Stimulus
    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        mon_en = 1'b1;
        repeat (3) @(negedge clk);

        // Full run: 104 cycles per pass, two passes
        base = cyc + 1;
        for (int p = 0; p < 2; p++) begin
            int o;
            o = p * 104;
            exp_ev(o + 0,  16'd56817, 1, 1, 3'd0, 0, "full_e0_play");
            exp_ev(o + 12, 16'd56817, 0, 1, 3'd0, 0, "full_e0_gap");
            exp_ev(o + 20, 16'd0,     0, 1, 3'd1, 0, "full_e1_rest");
            exp_ev(o + 36, 16'd0,     0, 1, 3'd2, 0, "full_e2_gap");
            for (int n = 3; n < 8; n++) begin
                exp_ev(o + 44 + (n - 3) * 12, 16'd37936, 1, 1, 3'(n), 0, "full_play");
                exp_ev(o + 48 + (n - 3) * 12, 16'd37936, 0, 1, 3'(n), 0, "full_gap");
            end
        end
        exp_ev(207, 16'd37936, 0, 1, 3'd7, 1, "full_done");
        exp_ev(208, 16'd37936, 0, 0, 3'd7, 0, "full_idle");
        pulse_start();
        wait_k(215);

        // Stop during cycle 5 of entry 0
        base = cyc + 1;
        exp_ev(0, 16'd56817, 1, 1, 3'd0, 0, "stop_play");
        exp_ev(6, 16'd56817, 0, 0, 3'd0, 0, "stop_idle");
        pulse_start();
        wait_k(5);
        pulse_stop();
        wait_k(30);

        // Start and Stop together from IDLE: nothing happens
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        repeat (20) @(negedge clk);

        // Start while busy is ignored
        base = cyc + 1;
        exp_ev(0,  16'd56817, 1, 1, 3'd0, 0, "busy_play");
        exp_ev(12, 16'd56817, 0, 1, 3'd0, 0, "busy_gap");
        exp_ev(20, 16'd0,     0, 1, 3'd1, 0, "busy_rest");
        exp_ev(23, 16'd0,     0, 0, 3'd1, 0, "busy_stop");
        pulse_start();
        wait_k(3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_k(14);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_k(22);
        pulse_stop();
        wait_k(40);

        // Reset mid-PLAY, then outputs hold reset values until the next Start
        base = cyc + 1;
        exp_ev(0, 16'd56817, 1, 1, 3'd0, 0, "rst_play");
        exp_ev(6, 16'd0,     0, 0, 3'd0, 0, "rst_zero");
        pulse_start();
        wait_k(5);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (12) @(negedge clk);

        base = cyc + 1;
        exp_ev(0, 16'd56817, 1, 1, 3'd0, 0, "post_rst_play");
        exp_ev(3, 16'd56817, 0, 0, 3'd0, 0, "post_rst_stop");
        pulse_start();
        wait_k(2);
        pulse_stop();
        wait_k(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alarm_melody_seq.md
ALARM_MELODY_SEQ -- requirements
Module: alarm_melody_seq

Interface
REQ-001 Parameter CLK_HZ, default 50000000, input clock frequency in Hz; sets the 1 ms tick period.
REQ-002 Parameter GAP_MS, default 20, silent gap in ms after every note.
REQ-003 Parameter REPEAT, default 3, number of full passes through the note table per Start (range 1..15).
REQ-004 Clk_50MHz  input  1  system clock; the only clock.
REQ-005 Rst_n  input  1  asynchronous active-low reset.
REQ-006 Start  input  1  one-cycle pulse; begins playback when idle.
REQ-007 Stop  input  1  one-cycle pulse; aborts playback.
REQ-008 Tone_div  output  16  half-period count minus 1 for the downstream buzzer divider (toggle every Tone_div+1 cycles).
REQ-009 Tone_on  output  1  high while the buzzer stage must sound.
REQ-010 Busy  output  1  high in any state other than IDLE.
REQ-011 Note_idx  output  3  index of the current note table entry.
REQ-012 Done  output  1  one-cycle pulse on normal completion.

Function
REQ-013 The 8-entry constant note table SHALL hold {div[15:0], dur_ms[9:0]} per entry; div=0 denotes a rest.
REQ-014 The FSM SHALL have states IDLE, PLAY, GAP.
REQ-015 IDLE + Start (Stop low) -> PLAY, Note_idx=0, pass counter=REPEAT, all on the next cycle.
REQ-016 PLAY SHALL last exactly dur_ms*(CLK_HZ/1000) cycles, then -> GAP.
REQ-017 GAP SHALL last exactly GAP_MS*(CLK_HZ/1000) cycles; it then -> PLAY with Note_idx+1, or after entry 7 -> PLAY with Note_idx=0 and pass counter-1.
REQ-018 At the end of GAP for entry 7 with pass counter=1, the FSM -> IDLE and Done pulses high for exactly that transition cycle.
REQ-019 A dur_ms=0 entry SHALL skip PLAY and go directly to GAP.
REQ-020 The ms prescaler and ms counter SHALL clear on every state entry, so no partial tick carries over.
REQ-021 Tone_on=1 only in PLAY with div!=0, and 0 in every other case.
REQ-022 Tone_div SHALL load the entry's div on PLAY entry and stay constant until the next PLAY entry.
REQ-023 Stop in any state -> IDLE on the next cycle, Tone_on=0, with no Done pulse.
REQ-024 Stop SHALL take priority when Start and Stop arrive in the same cycle.
REQ-025 Start while Busy SHALL be ignored, with no restart.
REQ-026 The prescaler SHALL be ceil(log2(CLK_HZ/1000)) bits wide and the ms counter 10 bits, with no wrap inside a state.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 While Rst_n=0: state=IDLE, Tone_div=0, Tone_on=0, Busy=0, Note_idx=0, Done=0, and all counters 0.
REQ-029 Reset assertion mid-note SHALL silence Tone_on asynchronously.
REQ-030 Rst_n deassertion SHALL be synchronised with a 2-flop release.

Structure
REQ-031 A shared package melody_pkg SHALL hold the state enum, the note-entry width constants and the note table contents.
REQ-032 One sub-module, ms_tick_gen (prescaler, clear input, 1-cycle tick output), is natural; everything else stays inline.

Verification (CLK_HZ=4000, i.e. 4 cycles/ms; GAP_MS=2; REPEAT=2; entry0={56817,3}, entry1={0,2}, entry2={28408,0}, rest {37936,1})
REQ-033 Start pulse -> next cycle Busy=1, Tone_on=1, Tone_div=56817; Tone_on high exactly 12 cycles, then low 8 cycles.
REQ-034 Entry1 (rest) -> Tone_on stays 0 for 8+8 cycles, Note_idx=1; entry2 (dur 0) -> goes straight to GAP, Tone_on never asserts, Note_idx=2.
REQ-035 Full run -> Note_idx wraps 7->0 once; Done pulses exactly once, 1 cycle, with Busy falling the following cycle.
REQ-036 Stop at cycle 5 of entry0 -> next cycle IDLE, Tone_on=0, no Done; Start and Stop in the same cycle from IDLE -> stays IDLE.
REQ-037 Start pulse while Busy -> no change to Note_idx or timing; Rst_n low mid-PLAY -> Tone_on=0 immediately, and after release all outputs hold reset values until the next Start.
